l2_port_arbiter: RTL and testbench
==================================

# l2_port_arbiter

Two-master arbiter that shares the single L2 wishbone slave port between the instruction-cache miss path and the data-cache miss path. It sits between the icache/dcache line-fill/write-back masters and the L2 cache. It grants one master per transaction, routes that master's request onto the L2 port and the L2 ACK back to it only, and keeps saturating contention counters. The counters are exported alongside the existing hit/miss counters for the performance-counter read path.

## Interface
- ADDR_W, 12: wishbone line address width (word address bits [15:4]).
- DATA_W, 128: line data width.
- SEL_W, 16: byte-select width.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- i_CYC, i_STB, i_WE  in  1 each  icache-side master request.
- i_ADR  in  ADDR_W  icache-side line address.
- i_SEL  in  SEL_W  icache-side byte selects.
- i_DAT_M  in  DATA_W  icache-side write data.
- i_ACK  out  1  ACK returned to the icache side.
- d_CYC, d_STB, d_WE, d_ADR, d_SEL, d_DAT_M  in  same as icache side  dcache-side master request.
- d_ACK  out  1  ACK returned to the dcache side.
- l2_CYC, l2_STB, l2_WE  out  1 each  request to L2.
- l2_ADR  out  ADDR_W  address to L2.
- l2_SEL  out  SEL_W  byte selects to L2.
- l2_DAT_M  out  DATA_W  write data to L2.
- l2_ACK  in  1  L2 ACK.
- l2_DAT_S  in  DATA_W  L2 read data; broadcast to both masters, unregistered.
- counter_clear  in  1  synchronous clear of both wait counters.
- icache_wait_counter  out  16  cycles the icache side requested without holding the grant.
- dcache_wait_counter  out  16  cycles the dcache side requested without holding the grant.

## Operation
- FSM states are IDLE, OWN_I and OWN_D.
- A master "requests" when its CYC & STB are both high.
- IDLE:
  - If neither master requests, stay in IDLE.
  - If only one master requests, go to that master's OWN state.
  - If both request, resolve by policy (see Configuration).
- OWN_x:
  - l2_CYC/STB/WE/ADR/SEL/DAT_M are combinationally driven from master x.
  - l2_ACK is routed to x_ACK. The other master's ACK is held at 0.
  - On l2_ACK=1, go to IDLE.
  - If x_CYC drops before ACK (abort), go to IDLE. l2_CYC/STB follow the master low the same cycle.
- In IDLE, all l2_* request outputs and both ACK outputs are 0, and l2_ADR/SEL/DAT_M are 0.
- The grant never changes while the owner's CYC is high and no ACK has been seen. There is no preemption.
- Wait counters:
  - Each counter increments by 1 on every cycle its master requests and the state is not its OWN state.
  - Each counter saturates at 16'hFFFF; it does not wrap.
  - counter_clear takes priority over increment.
- Reset values:
  - State is IDLE.
  - All outputs are 0.
  - Both counters are 0.
  - The last-winner flag is set to "dcache".

## Timing
- Arbitration latency is 1 cycle: a request first seen in IDLE at edge N is presented on l2_* during cycle N+1.
- ACK path is combinational: x_ACK = l2_ACK while in OWN_x.
- Minimum turnaround is 1 IDLE cycle after each ACK. Back-to-back transactions from the same or the other master therefore cost at least 1 bubble cycle.
- If a request and an ACK occur in the same cycle for different masters, the ACK completes the current owner; the new request is arbitrated in the following IDLE cycle.
- Asserting rst mid-transaction forces IDLE immediately (asynchronously). l2_CYC drops with no ACK forwarded. Masters must re-issue after reset.
- Counter updates are registered and visible the cycle after the counted cycle.

## Configuration
- L2_ARB_ROUND_ROBIN_EN:
  - Defined: on simultaneous requests in IDLE, grant the master that did not win the previous arbitration. The last-winner flag updates on every IDLE-to-OWN transition.
  - Undefined: fixed priority, dcache always wins simultaneous requests. The last-winner flag is not implemented, and icache can starve while dcache streams requests.

## Test plan
- Single icache read: i_CYC=i_STB=1, i_ADR=12'h0A3, L2 ACKs 3 cycles after l2_STB.
  - Expect l2_ADR=12'h0A3 one cycle after the request.
  - Expect i_ACK pulses once and d_ACK stays 0.
  - Expect state back in IDLE the cycle after ACK.
  - Expect icache_wait_counter=1.
- Simultaneous requests, dcache write d_ADR=12'h100, d_SEL=16'h0003:
  - Fixed priority: dcache served first. The icache then gets l2_ADR one IDLE cycle after d_ACK, and icache_wait_counter equals the dcache service cycles plus 2.
  - Round robin with both masters continuously re-requesting: grants alternate D, I, D, I.
- Abort: grant icache, drop i_CYC before l2_ACK.
  - Expect l2_CYC=0 the same cycle.
  - Expect IDLE on the next edge.
  - Expect a late l2_ACK not to be forwarded to either master.
- Async reset mid-OWN_D:
  - Expect all outputs 0 without waiting for a clock edge.
  - Expect counters 0.
  - Expect the next request to take 1 cycle to be granted.
- Saturation:
  - Hold the icache request while dcache owns the port for 70000 cycles (ACK withheld).
  - Expect icache_wait_counter=16'hFFFF with no wrap.
  - Pulse counter_clear during an increment cycle: expect 0.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// ============================================================================
// l2_port_arbiter
// ----------------------------------------------------------------------------
// Shares the single L2 wishbone slave port between the icache miss master
// and the dcache miss master. Each transaction gets exactly one owner. The
// owner's request is routed onto l2_* and l2_ACK is routed back to the owner
// only. Two saturating wait counters record how long each master has
// requested without holding the port. They feed the performance-counter
// read path.
//
// Build option:
//   L2_ARB_ROUND_ROBIN_EN  When defined, simultaneous requests in IDLE go to
//                          the master that did not win the previous
//                          arbitration. When undefined, dcache always wins
//                          simultaneous requests (fixed priority), and the
//                          last-winner flag does not exist.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   i_CYC/STB/WE/ADR/SEL/DAT_M  icache-side wishbone master request
//   i_ACK, i_DAT_S            ACK and read data returned to the icache side
//   d_CYC/STB/WE/ADR/SEL/DAT_M  dcache-side wishbone master request
//   d_ACK, d_DAT_S            ACK and read data returned to the dcache side
//   l2_CYC/STB/WE/ADR/SEL/DAT_M request presented to the L2 slave
//   l2_ACK, l2_DAT_S          L2 slave response
//   counter_clear             synchronous clear of both wait counters
//   icache_wait_counter       icache cycles spent requesting without the grant
//   dcache_wait_counter       dcache cycles spent requesting without the grant
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module l2_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 128,
  parameter int SEL_W  = 16
) (
  input  logic              clk,
  input  logic              rst,

  // icache-side master
  input  logic              i_CYC,
  input  logic              i_STB,
  input  logic              i_WE,
  input  logic [ADDR_W-1:0] i_ADR,
  input  logic [SEL_W-1:0]  i_SEL,
  input  logic [DATA_W-1:0] i_DAT_M,
  output logic              i_ACK,
  output logic [DATA_W-1:0] i_DAT_S,

  // dcache-side master
  input  logic              d_CYC,
  input  logic              d_STB,
  input  logic              d_WE,
  input  logic [ADDR_W-1:0] d_ADR,
  input  logic [SEL_W-1:0]  d_SEL,
  input  logic [DATA_W-1:0] d_DAT_M,
  output logic              d_ACK,
  output logic [DATA_W-1:0] d_DAT_S,

  // shared L2 slave port
  output logic              l2_CYC,
  output logic              l2_STB,
  output logic              l2_WE,
  output logic [ADDR_W-1:0] l2_ADR,
  output logic [SEL_W-1:0]  l2_SEL,
  output logic [DATA_W-1:0] l2_DAT_M,
  input  logic              l2_ACK,
  input  logic [DATA_W-1:0] l2_DAT_S,

  // performance counters
  input  logic              counter_clear,
  output logic [15:0]       icache_wait_counter,
  output logic [15:0]       dcache_wait_counter
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic i_req;
  logic d_req;

  assign i_req = i_CYC & i_STB;
  assign d_req = d_CYC & d_STB;

  // Read data is not steered. Only the owner sees an ACK, so the other
  // master ignores the broadcast data.
  assign i_DAT_S = l2_DAT_S;
  assign d_DAT_S = l2_DAT_S;

  // --------------------------------------------------------------------------
  // Last-winner flag (round-robin build only). Set means dcache won the most
  // recent IDLE-to-OWN arbitration. It resets to dcache, so the first
  // simultaneous request after reset goes to icache.
  // --------------------------------------------------------------------------
`ifdef L2_ARB_ROUND_ROBIN_EN
  logic last_d_q;
  logic last_d_d;

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == IDLE) begin
      if (state_d == OWN_D) begin
        last_d_d = 1'b1;
      end else if (state_d == OWN_I) begin
        last_d_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_q <= 1'b1;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // The owner keeps the port until L2 ACKs or the owner drops CYC. There is
  // no preemption. Every transaction returns to IDLE, so a new request always
  // needs at least one bubble cycle before it is granted.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
          state_d = last_d_q ? OWN_I : OWN_D;
`else
          state_d = OWN_D;
`endif
        end else if (d_req) begin
          state_d = OWN_D;
        end else if (i_req) begin
          state_d = OWN_I;
        end
      end
      OWN_I: begin
        if (l2_ACK || !i_CYC) begin
          state_d = IDLE;
        end
      end
      OWN_D: begin
        if (l2_ACK || !d_CYC) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // The owner's request is passed through combinationally. If the owner
  // aborts by dropping CYC, l2_CYC follows it low in the same cycle. In IDLE
  // every request field is forced to zero.
  // --------------------------------------------------------------------------
  always_comb begin
    l2_CYC   = 1'b0;
    l2_STB   = 1'b0;
    l2_WE    = 1'b0;
    l2_ADR   = '0;
    l2_SEL   = '0;
    l2_DAT_M = '0;
    i_ACK    = 1'b0;
    d_ACK    = 1'b0;
    unique case (state_q)
      OWN_I: begin
        l2_CYC   = i_CYC;
        l2_STB   = i_STB;
        l2_WE    = i_WE;
        l2_ADR   = i_ADR;
        l2_SEL   = i_SEL;
        l2_DAT_M = i_DAT_M;
        i_ACK    = l2_ACK;
      end
      OWN_D: begin
        l2_CYC   = d_CYC;
        l2_STB   = d_STB;
        l2_WE    = d_WE;
        l2_ADR   = d_ADR;
        l2_SEL   = d_SEL;
        l2_DAT_M = d_DAT_M;
        d_ACK    = l2_ACK;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Wait counters. Index 0 is icache and index 1 is dcache.
  // A counter advances on any cycle its master requests while the port is
  // not in that master's OWN state. That includes IDLE arbitration cycles
  // and the bubble after the other master's ACK. The counter saturates at
  // all-ones. A clear wins over a same-cycle increment.
  // --------------------------------------------------------------------------
  logic [1:0]       req_vec;
  logic [1:0]       own_vec;
  logic [1:0][15:0] wait_cnt_vec;

  assign req_vec = {d_req, i_req};
  assign own_vec = {(state_q == OWN_D), (state_q == OWN_I)};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_wait_cnt
      logic [15:0] cnt_q;
      logic [15:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (counter_clear) begin
          cnt_d = 16'h0000;
        end else if (req_vec[gi] && !own_vec[gi] && (cnt_q != 16'hFFFF)) begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= 16'h0000;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign wait_cnt_vec[gi] = cnt_q;
    end
  endgenerate

  assign icache_wait_counter = wait_cnt_vec[0];
  assign dcache_wait_counter = wait_cnt_vec[1];

endmodule

`default_nettype wire

// File: tb/tb_l2_port_arbiter.sv
`timescale 1ns/1ps

module tb_l2_port_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 128;
  localparam int SEL_W  = 16;

  logic              clk;
  logic              rst;
  logic              i_CYC, i_STB, i_WE;
  logic [ADDR_W-1:0] i_ADR;
  logic [SEL_W-1:0]  i_SEL;
  logic [DATA_W-1:0] i_DAT_M;
  logic              i_ACK;
  logic [DATA_W-1:0] i_DAT_S;
  logic              d_CYC, d_STB, d_WE;
  logic [ADDR_W-1:0] d_ADR;
  logic [SEL_W-1:0]  d_SEL;
  logic [DATA_W-1:0] d_DAT_M;
  logic              d_ACK;
  logic [DATA_W-1:0] d_DAT_S;
  logic              l2_CYC, l2_STB, l2_WE;
  logic [ADDR_W-1:0] l2_ADR;
  logic [SEL_W-1:0]  l2_SEL;
  logic [DATA_W-1:0] l2_DAT_M;
  logic              l2_ACK;
  logic [DATA_W-1:0] l2_DAT_S;
  logic              counter_clear;
  logic [15:0]       icache_wait_counter;
  logic [15:0]       dcache_wait_counter;

  l2_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .SEL_W (SEL_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_CYC              (i_CYC),
    .i_STB              (i_STB),
    .i_WE               (i_WE),
    .i_ADR              (i_ADR),
    .i_SEL              (i_SEL),
    .i_DAT_M            (i_DAT_M),
    .i_ACK              (i_ACK),
    .i_DAT_S            (i_DAT_S),
    .d_CYC              (d_CYC),
    .d_STB              (d_STB),
    .d_WE               (d_WE),
    .d_ADR              (d_ADR),
    .d_SEL              (d_SEL),
    .d_DAT_M            (d_DAT_M),
    .d_ACK              (d_ACK),
    .d_DAT_S            (d_DAT_S),
    .l2_CYC             (l2_CYC),
    .l2_STB             (l2_STB),
    .l2_WE              (l2_WE),
    .l2_ADR             (l2_ADR),
    .l2_SEL             (l2_SEL),
    .l2_DAT_M           (l2_DAT_M),
    .l2_ACK             (l2_ACK),
    .l2_DAT_S           (l2_DAT_S),
    .counter_clear      (counter_clear),
    .icache_wait_counter(icache_wait_counter),
    .dcache_wait_counter(dcache_wait_counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port (0 none, 1 icache, 2 dcache) and the
  // two wait counts as plain integers.
  int m_owner = 0;
  int m_icnt  = 0;
  int m_dcnt  = 0;
`ifdef L2_ARB_ROUND_ROBIN_EN
  bit m_last_d = 1'b1;
`endif

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_icnt  = 0;
    m_dcnt  = 0;
`ifdef L2_ARB_ROUND_ROBIN_EN
    m_last_d = 1'b1;
`endif
  endtask

  // Mid-cycle compare of every DUT output against the model.
  task automatic mid();
    bit oi, od;
    @(negedge clk);
    if (!rst) begin
      oi = (m_owner == 1);
      od = (m_owner == 2);
      chk("m_l2_CYC", l2_CYC, oi ? i_CYC : (od ? d_CYC : 1'b0));
      chk("m_l2_STB", l2_STB, oi ? i_STB : (od ? d_STB : 1'b0));
      chk("m_l2_WE",  l2_WE,  oi ? i_WE  : (od ? d_WE  : 1'b0));
      chk("m_l2_ADR", l2_ADR, oi ? i_ADR : (od ? d_ADR : 12'h000));
      chk("m_l2_SEL", l2_SEL, oi ? i_SEL : (od ? d_SEL : 16'h0000));
      chk("m_l2_DAT_M", l2_DAT_M, oi ? i_DAT_M : (od ? d_DAT_M : 128'h0));
      chk("m_i_ACK", i_ACK, oi & l2_ACK);
      chk("m_d_ACK", d_ACK, od & l2_ACK);
      chk("m_i_DAT_S", i_DAT_S, l2_DAT_S);
      chk("m_d_DAT_S", d_DAT_S, l2_DAT_S);
      chk("m_icnt", icache_wait_counter, m_icnt[15:0]);
      chk("m_dcnt", dcache_wait_counter, m_dcnt[15:0]);
    end
  endtask

  // Advance the model over the coming edge, then move to just after it.
  task automatic adv();
    bit ri, rd;
    if (rst) begin
      model_reset();
    end else begin
      ri = i_CYC & i_STB;
      rd = d_CYC & d_STB;
      if (counter_clear) m_icnt = 0;
      else if (ri && m_owner != 1 && m_icnt < 65535) m_icnt++;
      if (counter_clear) m_dcnt = 0;
      else if (rd && m_owner != 2 && m_dcnt < 65535) m_dcnt++;
      case (m_owner)
        0: begin
          if (ri && rd) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
            m_owner = m_last_d ? 1 : 2;
`else
            m_owner = 2;
`endif
          end else if (rd) m_owner = 2;
          else if (ri) m_owner = 1;
`ifdef L2_ARB_ROUND_ROBIN_EN
          if (m_owner != 0) m_last_d = (m_owner == 2);
`endif
        end
        1: if (l2_ACK || !i_CYC) m_owner = 0;
        default: if (l2_ACK || !d_CYC) m_owner = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    mid();
    adv();
  endtask

  int grants[4];
  int exp_grants[4];
  int ngrant;

  initial begin
    rst = 1'b1;
    i_CYC = 0; i_STB = 0; i_WE = 0; i_ADR = '0; i_SEL = '0; i_DAT_M = '0;
    d_CYC = 0; d_STB = 0; d_WE = 0; d_ADR = '0; d_SEL = '0; d_DAT_M = '0;
    l2_ACK = 0; l2_DAT_S = 128'hCAFE_0000_1111_2222_3333_4444_5555_6666;
    counter_clear = 0;

    // Reset state
    cyc();
    mid();
    chk("rst_l2_CYC", l2_CYC, 1'b0);
    chk("rst_l2_ADR", l2_ADR, 12'h000);
    chk("rst_i_ACK", i_ACK, 1'b0);
    chk("rst_d_ACK", d_ACK, 1'b0);
    chk("rst_icnt", icache_wait_counter, 16'h0000);
    chk("rst_dcnt", dcache_wait_counter, 16'h0000);
    adv();
    rst = 1'b0;
    cyc();
    $display("txn reset: done");

    // Single icache read, ACK three cycles after l2_STB first appears
    i_CYC = 1; i_STB = 1; i_WE = 0; i_ADR = 12'h0A3; i_SEL = 16'hFFFF;
    i_DAT_M = 128'h1234;
    mid();
    chk("t1_idle_cyc", l2_CYC, 1'b0);
    adv();
    mid();
    chk("t1_cyc", l2_CYC, 1'b1);
    chk("t1_adr", l2_ADR, 12'h0A3);
    chk("t1_icnt", icache_wait_counter, 16'd1);
    adv();
    cyc();
    cyc();
    l2_ACK = 1;
    mid();
    chk("t1_i_ack", i_ACK, 1'b1);
    chk("t1_d_ack", d_ACK, 1'b0);
    chk("t1_i_dat", i_DAT_S, 128'hCAFE_0000_1111_2222_3333_4444_5555_6666);
    adv();
    l2_ACK = 0; i_CYC = 0; i_STB = 0;
    mid();
    chk("t1_back_idle", l2_CYC, 1'b0);
    chk("t1_icnt_hold", icache_wait_counter, 16'd1);
    adv();
    $display("txn icache read 0A3: icnt=%0d", icache_wait_counter);

    // Simultaneous: dcache write vs icache read. dcache is served first in
    // both builds (icache won last time).
    d_CYC = 1; d_STB = 1; d_WE = 1; d_ADR = 12'h100; d_SEL = 16'h0003;
    d_DAT_M = 128'hD00D;
    i_CYC = 1; i_STB = 1; i_ADR = 12'h0A4;
    cyc();
    mid();
    chk("t2_d_adr", l2_ADR, 12'h100);
    chk("t2_d_sel", l2_SEL, 16'h0003);
    chk("t2_d_we", l2_WE, 1'b1);
    adv();
    cyc();
    l2_ACK = 1;
    mid();
    chk("t2_d_ack", d_ACK, 1'b1);
    chk("t2_i_noack", i_ACK, 1'b0);
    adv();
    l2_ACK = 0; d_CYC = 0; d_STB = 0; d_WE = 0;
    mid();
    chk("t2_bubble", l2_CYC, 1'b0);
    adv();
    mid();
    chk("t2_i_adr", l2_ADR, 12'h0A4);
    chk("t2_icnt", icache_wait_counter, 16'd6);
    adv();
    l2_ACK = 1;
    cyc();
    l2_ACK = 0; i_CYC = 0; i_STB = 0;
    cyc();
    $display("txn simultaneous d100/i0A4: icnt=%0d", icache_wait_counter);

    // Both masters keep requesting, L2 ACKs immediately every time
    i_CYC = 1; i_STB = 1; i_ADR = 12'h0B0;
    d_CYC = 1; d_STB = 1; d_WE = 0; d_ADR = 12'h1B0;
    l2_ACK = 1;
    ngrant = 0;
    for (int k = 0; k < 8; k++) begin
      mid();
      if (l2_CYC && ngrant < 4) begin
        grants[ngrant] = d_ACK ? 2 : 1;
        ngrant++;
      end
      adv();
    end
`ifdef L2_ARB_ROUND_ROBIN_EN
    exp_grants = '{2, 1, 2, 1};
`else
    exp_grants = '{2, 2, 2, 2};
`endif
    chk("t3_ngrant", ngrant, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_grant%0d", k), grants[k], exp_grants[k]);
    end
    l2_ACK = 0; i_CYC = 0; i_STB = 0; d_CYC = 0; d_STB = 0;
    cyc();
    $display("txn contention stream: grants=%0d%0d%0d%0d", grants[0], grants[1], grants[2], grants[3]);

    // Abort: icache drops CYC before any ACK
    i_CYC = 1; i_STB = 1; i_ADR = 12'h055;
    cyc();
    mid();
    chk("t4_granted", l2_CYC, 1'b1);
    adv();
    i_CYC = 0; i_STB = 0;
    mid();
    chk("t4_abort_cyc", l2_CYC, 1'b0);
    chk("t4_abort_stb", l2_STB, 1'b0);
    adv();
    l2_ACK = 1;
    mid();
    chk("t4_late_i_ack", i_ACK, 1'b0);
    chk("t4_late_d_ack", d_ACK, 1'b0);
    chk("t4_idle_adr", l2_ADR, 12'h000);
    adv();
    l2_ACK = 0;
    cyc();
    $display("txn icache abort 055: done");

    // Asynchronous reset while dcache owns the port
    d_CYC = 1; d_STB = 1; d_WE = 1; d_ADR = 12'h200; d_SEL = 16'h00F0;
    i_CYC = 1; i_STB = 1; i_ADR = 12'h0C0;
    cyc();
    mid();
    chk("t5_own_d", l2_ADR, 12'h200);
    #2;
    rst = 1'b1;
    l2_ACK = 1;
    #1;
    chk("t5_rst_cyc", l2_CYC, 1'b0);
    chk("t5_rst_stb", l2_STB, 1'b0);
    chk("t5_rst_we", l2_WE, 1'b0);
    chk("t5_rst_adr", l2_ADR, 12'h000);
    chk("t5_rst_d_ack", d_ACK, 1'b0);
    chk("t5_rst_icnt", icache_wait_counter, 16'h0000);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0; l2_ACK = 0; i_CYC = 0; i_STB = 0;
    mid();
    chk("t5_regrant_idle", l2_CYC, 1'b0);
    adv();
    mid();
    chk("t5_regrant_cyc", l2_CYC, 1'b1);
    chk("t5_regrant_adr", l2_ADR, 12'h200);
    adv();
    l2_ACK = 1;
    cyc();
    l2_ACK = 0; d_CYC = 0; d_STB = 0; d_WE = 0;
    cyc();
    $display("txn async reset during d200: done");

    // Saturation: dcache holds the port without ACK, icache waits
    d_CYC = 1; d_STB = 1; d_ADR = 12'h300;
    cyc();
    i_CYC = 1; i_STB = 1; i_ADR = 12'h0D0;
    for (int k = 0; k < 70000; k++) begin
      cyc();
    end
    mid();
    chk("t6_sat", icache_wait_counter, 16'hFFFF);
    adv();
    counter_clear = 1;
    cyc();
    counter_clear = 0;
    mid();
    chk("t6_clear", icache_wait_counter, 16'h0000);
    chk("t6_clear_d", dcache_wait_counter, 16'h0000);
    adv();
    mid();
    chk("t6_resume", icache_wait_counter, 16'h0001);
    adv();
    l2_ACK = 1;
    cyc();
    l2_ACK = 0; d_CYC = 0; d_STB = 0; i_CYC = 0; i_STB = 0;
    cyc();
    $display("txn saturation/clear: icnt=%0d", icache_wait_counter);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
